// File: rtl/led_pkg.sv
// Shared definitions for the LED matrix scan/PWM driver.
//   - mode encodings as seen on the mode_i pins
//   - controller state and self-test phase enums
//   - grey-level count helper (LEVELS = 2^GRAY_BITS - 1)
package led_pkg;

   localparam logic [1:0] MODE_OFF  = 2'd0;
   localparam logic [1:0] MODE_SCAN = 2'd1;
   localparam logic [1:0] MODE_TEST = 2'd2;

   typedef enum logic [1:0] {
      ST_OFF,
      ST_BLANK,
      ST_ACTIVE,
      ST_TEST
   } state_e;

   typedef enum logic [1:0] {
      PH_CH0,
      PH_CH1,
      PH_OFF,
      PH_DONE
   } phase_e;

   function automatic int unsigned levels_f(input int unsigned gray_bits);
      return (32'd1 << gray_bits) - 32'd1;
   endfunction

endpackage

// File: rtl/led_pwm_compare.sv
// Column-enable generator for one displayed row.
//   val_i  : N packed grey values, entry i at [i*GRAY_BITS +: GRAY_BITS]
//   slot_i : current PWM slot
//   en_o   : bit i high when value i is strictly greater than the slot,
//            so 0 is never lit and the full-scale value is lit every slot
module led_pwm_compare #(
   parameter int unsigned N         = 16,
   parameter int unsigned GRAY_BITS = 4
) (
   input  logic [N*GRAY_BITS-1:0] val_i,
   input  logic [GRAY_BITS-1:0]   slot_i,
   output logic [N-1:0]           en_o
);

   always_comb begin
      en_o = '0;
      for (int i = 0; i < N; i++)
         en_o[i] = (val_i[i*GRAY_BITS +: GRAY_BITS] > slot_i);
   end

endmodule

// File: rtl/led_matrix_scan_pwm.sv
// LED matrix driver with per-pixel PWM, row blanking and a self-test.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   mode_i            : OFF / SCAN / TEST (reserved code behaves as OFF)
//   wr_en_i, wr_row_i, wr_col_i, wr_data_i : frame-buffer write port
//   row_out_o         : one-hot row drive
//   col_out_o         : column drive, channel c at [c*COLS +: COLS]
//   frame_start_o     : pulse on the first lit cycle of row 0
//   test_done_o       : self-test finished, held while mode stays TEST
//
// state     | meaning
// ST_OFF    | everything dark, row index parked at 0
// ST_BLANK  | all-off gap before a row; shadow loaded on its last cycle
// ST_ACTIVE | row lit, PWM slot counter sweeping 0..LEVELS-1
// ST_TEST   | self-test phases CH0 -> CH1 -> OFF -> DONE
module led_matrix_scan_pwm
   import led_pkg::*;
#(
   parameter int unsigned ROWS       = 8,
   parameter int unsigned COLS       = 8,
   parameter int unsigned CHANNELS   = 2,
   parameter int unsigned GRAY_BITS  = 4,
   parameter int unsigned SLOT_CLKS  = 1,
   parameter int unsigned BLANK_CLKS = 2,
   parameter int unsigned TEST_CLKS  = 16
) (
   input  logic                                        clk_i,
   input  logic                                        rst_i,
   input  logic [1:0]                                  mode_i,
   input  logic                                        wr_en_i,
   input  logic [$clog2(ROWS)-1:0]                     wr_row_i,
   input  logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0]  wr_col_i,
   input  logic [CHANNELS*GRAY_BITS-1:0]               wr_data_i,
   output logic [ROWS-1:0]                             row_out_o,
   output logic [CHANNELS*COLS-1:0]                    col_out_o,
   output logic                                        frame_start_o,
   output logic                                        test_done_o
);

   localparam int unsigned LEVELS  = levels_f(GRAY_BITS);
   localparam int unsigned RW      = $clog2(ROWS);
   localparam int unsigned PIX_W   = CHANNELS*GRAY_BITS;
   localparam int unsigned NCMP    = CHANNELS*COLS;
   localparam int unsigned MAX_BS  = (BLANK_CLKS > SLOT_CLKS) ? BLANK_CLKS : SLOT_CLKS;
   localparam int unsigned TMR_MAX = (TEST_CLKS > MAX_BS) ? TEST_CLKS : MAX_BS;
   localparam int unsigned TW      = $clog2(TMR_MAX + 1);
   localparam int unsigned CH1     = (CHANNELS > 1) ? 1 : 0;

   state_e                  state_q, state_d;
   phase_e                  phase_q, phase_d;
   logic [TW-1:0]           tmr_q, tmr_d;
   logic [GRAY_BITS-1:0]    slot_q, slot_d;
   logic [RW-1:0]           row_idx_q, row_idx_d;
   logic                    shadow_ld;

   logic [PIX_W-1:0]        fb_q [ROWS][COLS];
   logic [PIX_W-1:0]        shadow_q [COLS];
   logic [NCMP*GRAY_BITS-1:0] shadow_flat;
   logic [NCMP-1:0]         col_en;

   logic [ROWS-1:0]         row_out_q, row_out_d;
   logic [NCMP-1:0]         col_out_q, col_out_d;
   logic                    fs_q, fs_d, done_q, done_d;

   logic                    mode_scan, mode_test;

   assign mode_scan = (mode_i == MODE_SCAN);
   assign mode_test = (mode_i == MODE_TEST);

   // Frame buffer and row shadow. The shadow copy reads the buffer before a
   // same-edge write lands, so a row never changes during its own dwell.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
               fb_q[r][c] <= '0;
         for (int c = 0; c < COLS; c++)
            shadow_q[c] <= '0;
      end else begin
         if (wr_en_i && (32'(wr_row_i) < ROWS) && (32'(wr_col_i) < COLS))
            fb_q[wr_row_i][wr_col_i] <= wr_data_i;
         if (shadow_ld)
            for (int c = 0; c < COLS; c++)
               shadow_q[c] <= fb_q[row_idx_q][c];
      end
   end

   // Regroup shadow pixels into column-output order (channel-major).
   always_comb begin
      shadow_flat = '0;
      for (int c = 0; c < CHANNELS; c++)
         for (int k = 0; k < COLS; k++)
            shadow_flat[(c*COLS + k)*GRAY_BITS +: GRAY_BITS] =
               shadow_q[k][c*GRAY_BITS +: GRAY_BITS];
   end

   led_pwm_compare #(
      .N         (NCMP),
      .GRAY_BITS (GRAY_BITS)
   ) u_cmp (
      .val_i  (shadow_flat),
      .slot_i (slot_q),
      .en_o   (col_en)
   );

   // State register, counters and registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_OFF;
         phase_q   <= PH_CH0;
         tmr_q     <= '0;
         slot_q    <= '0;
         row_idx_q <= '0;
         row_out_q <= '0;
         col_out_q <= '0;
         fs_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         tmr_q     <= tmr_d;
         slot_q    <= slot_d;
         row_idx_q <= row_idx_d;
         row_out_q <= row_out_d;
         col_out_q <= col_out_d;
         fs_q      <= fs_d;
         done_q    <= done_d;
      end
   end

   // Next state. A mode change always wins over the running sequence.
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      tmr_d     = tmr_q;
      slot_d    = slot_q;
      row_idx_d = row_idx_q;
      shadow_ld = 1'b0;
      if (!mode_scan && !mode_test) begin
         state_d   = ST_OFF;
         phase_d   = PH_CH0;
         tmr_d     = '0;
         slot_d    = '0;
         row_idx_d = '0;
      end else if (mode_scan && (state_q != ST_BLANK) && (state_q != ST_ACTIVE)) begin
         state_d   = ST_BLANK;
         tmr_d     = TW'(BLANK_CLKS - 1);
         slot_d    = '0;
         row_idx_d = '0;
      end else if (mode_test && (state_q != ST_TEST)) begin
         state_d   = ST_TEST;
         phase_d   = PH_CH0;
         tmr_d     = TW'(TEST_CLKS - 1);
         row_idx_d = '0;
      end else begin
         unique case (state_q)
            ST_BLANK: begin
               if (tmr_q == '0) begin
                  state_d   = ST_ACTIVE;
                  slot_d    = '0;
                  tmr_d     = TW'(SLOT_CLKS - 1);
                  shadow_ld = 1'b1;
               end else begin
                  tmr_d = tmr_q - 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (tmr_q != '0) begin
                  tmr_d = tmr_q - 1'b1;
               end else if (slot_q == GRAY_BITS'(LEVELS - 1)) begin
                  state_d   = ST_BLANK;
                  tmr_d     = TW'(BLANK_CLKS - 1);
                  row_idx_d = (row_idx_q == RW'(ROWS - 1)) ? '0 : row_idx_q + 1'b1;
               end else begin
                  slot_d = slot_q + 1'b1;
                  tmr_d  = TW'(SLOT_CLKS - 1);
               end
            end
            ST_TEST: begin
               if (phase_q != PH_DONE) begin
                  if (tmr_q != '0) begin
                     tmr_d = tmr_q - 1'b1;
                  end else begin
                     tmr_d = TW'(TEST_CLKS - 1);
                     unique case (phase_q)
                        PH_CH0:  phase_d = PH_CH1;
                        PH_CH1:  phase_d = PH_OFF;
                        default: phase_d = PH_DONE;
                     endcase
                  end
               end
            end
            default: state_d = ST_OFF;
         endcase
      end
   end

   // Output decode. Gated by the live mode so that leaving SCAN or TEST
   // darkens the pins on the very next edge.
   always_comb begin
      row_out_d = '0;
      col_out_d = '0;
      fs_d      = 1'b0;
      done_d    = 1'b0;
      unique case (state_q)
         ST_ACTIVE: begin
            if (mode_scan) begin
               row_out_d[row_idx_q] = 1'b1;
               col_out_d = col_en;
               fs_d = (row_idx_q == '0) && (slot_q == '0) &&
                      (tmr_q == TW'(SLOT_CLKS - 1));
            end
         end
         ST_TEST: begin
            if (mode_test) begin
               unique case (phase_q)
                  PH_CH0: begin
                     row_out_d = '1;
                     col_out_d[0 +: COLS] = '1;
                  end
                  PH_CH1: begin
                     row_out_d = '1;
                     col_out_d[CH1*COLS +: COLS] = '1;
                  end
                  PH_DONE: done_d = 1'b1;
                  default: ;
               endcase
            end
         end
         default: ;
      endcase
   end

   assign row_out_o     = row_out_q;
   assign col_out_o     = col_out_q;
   assign frame_start_o = fs_q;
   assign test_done_o   = done_q;

endmodule
